// File: rtl/sra_arbiter_if.sv
// Request/response bundle between upstream masters, the arbiter and the downstream slave.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface sra_arbiter_if #(
    parameter int unsigned DATA_WIDTH_BYTES = 4,
    parameter int unsigned ADDR_WIDTH       = 8,
    parameter int unsigned M_USER_BITS      = 2,
    parameter int unsigned S_USER_BITS      = 2,
    parameter int unsigned NUM_MASTERS      = 4
);
    localparam int unsigned DW = 8 * DATA_WIDTH_BYTES;

    logic [NUM_MASTERS-1:0]             m_req_valid;
    logic [NUM_MASTERS-1:0]             m_req_ready;
    logic [NUM_MASTERS*DW-1:0]          m_req_data;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_req_addr;
    logic [NUM_MASTERS*M_USER_BITS-1:0] m_req_user;

    logic [NUM_MASTERS-1:0]             m_rsp_valid;
    logic [NUM_MASTERS-1:0]             m_rsp_ready;
    logic [DW-1:0]                      m_rsp_data;
    logic [ADDR_WIDTH-1:0]              m_rsp_addr;
    logic [S_USER_BITS-1:0]             m_rsp_user;
    logic                               m_rsp_err;

    logic                               s_req_valid;
    logic                               s_req_ready;
    logic [DW-1:0]                      s_req_data;
    logic [ADDR_WIDTH-1:0]              s_req_addr;
    logic [M_USER_BITS-1:0]             s_req_user;

    logic                               s_rsp_valid;
    logic                               s_rsp_ready;
    logic [DW-1:0]                      s_rsp_data;
    logic [ADDR_WIDTH-1:0]              s_rsp_addr;
    logic [S_USER_BITS-1:0]             s_rsp_user;

    modport slave (
        input  m_req_valid, m_req_data, m_req_addr, m_req_user, m_rsp_ready,
        input  s_req_ready, s_rsp_valid, s_rsp_data, s_rsp_addr, s_rsp_user,
        output m_req_ready, m_rsp_valid, m_rsp_data, m_rsp_addr, m_rsp_user, m_rsp_err,
        output s_req_valid, s_req_data, s_req_addr, s_req_user, s_rsp_ready
    );

    modport master (
        output m_req_valid, m_req_data, m_req_addr, m_req_user, m_rsp_ready,
        output s_req_ready, s_rsp_valid, s_rsp_data, s_rsp_addr, s_rsp_user,
        input  m_req_ready, m_rsp_valid, m_rsp_data, m_rsp_addr, m_rsp_user, m_rsp_err,
        input  s_req_valid, s_req_data, s_req_addr, s_req_user, s_rsp_ready
    );
endinterface

// File: rtl/sra_arbiter.sv
// Round-robin N:1 arbiter with a single outstanding transaction, response timeout and
// a saturating counter of slave responses that arrive when nobody is waiting for one.
module sra_arbiter #(
    parameter int unsigned DATA_WIDTH_BYTES = 4,
    parameter int unsigned ADDR_WIDTH       = 8,
    parameter int unsigned M_USER_BITS      = 2,
    parameter int unsigned S_USER_BITS      = 2,
    parameter int unsigned NUM_MASTERS      = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic        clk,
    input  logic        rst,
    sra_arbiter_if.slave bus,
    output logic [7:0]  stray_cnt
);
    localparam int unsigned DW = 8 * DATA_WIDTH_BYTES;
    localparam int unsigned GW = $clog2(NUM_MASTERS);
    localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimerLast =
        TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [7:0]             stray_q, stray_d;
    logic [DW-1:0]          req_data_q, req_data_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [M_USER_BITS-1:0] req_user_q, req_user_d;
    logic [DW-1:0]          rsp_data_q, rsp_data_d;
    logic [ADDR_WIDTH-1:0]  rsp_addr_q, rsp_addr_d;
    logic [S_USER_BITS-1:0] rsp_user_q, rsp_user_d;
    logic                   rsp_err_q, rsp_err_d;

    logic          found;
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;

    // First requesting master at or above rr_ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = '0;
        for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
            idx = GW'((32'(rr_ptr_q) + j) % NUM_MASTERS);
            if (!found && bus.m_req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        timer_d         = timer_q;
        stray_d         = stray_q;
        req_data_d      = req_data_q;
        req_addr_d      = req_addr_q;
        req_user_d      = req_user_q;
        rsp_data_d      = rsp_data_q;
        rsp_addr_d      = rsp_addr_q;
        rsp_user_d      = rsp_user_q;
        rsp_err_d       = rsp_err_q;
        bus.m_req_ready = '0;

        unique case (state_q)
            StIdle: begin
                // Ready is suppressed while reset is asserted even though the state reads idle.
                if (found && rst) begin
                    bus.m_req_ready = NUM_MASTERS'(1) << pick;
                    grant_d         = pick;
                    req_data_d      = bus.m_req_data[32'(pick) * DW +: DW];
                    req_addr_d      = bus.m_req_addr[32'(pick) * ADDR_WIDTH +: ADDR_WIDTH];
                    req_user_d      = bus.m_req_user[32'(pick) * M_USER_BITS +: M_USER_BITS];
                    state_d         = StReq;
                end
            end
            StReq: begin
                if (bus.s_req_ready) begin
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A real response beats a timeout expiring in the same cycle.
                if (bus.s_rsp_valid) begin
                    rsp_data_d = bus.s_rsp_data;
                    rsp_addr_d = bus.s_rsp_addr;
                    rsp_user_d = bus.s_rsp_user;
                    rsp_err_d  = 1'b0;
                    state_d    = StRsp;
                end else if (TIMEOUT_CYCLES != 0 && timer_q == TimerLast) begin
                    rsp_data_d = '0;
                    rsp_addr_d = req_addr_q;
                    rsp_user_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StRsp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRsp: begin
                if (bus.m_rsp_ready[grant_q]) begin
                    rr_ptr_d = (32'(grant_q) == NUM_MASTERS - 1) ? '0 : grant_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StWait && bus.s_rsp_valid && stray_q != 8'hFF) begin
            stray_d = stray_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            timer_q    <= '0;
            stray_q    <= '0;
            req_data_q <= '0;
            req_addr_q <= '0;
            req_user_q <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_user_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            timer_q    <= timer_d;
            stray_q    <= stray_d;
            req_data_q <= req_data_d;
            req_addr_q <= req_addr_d;
            req_user_q <= req_user_d;
            rsp_data_q <= rsp_data_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_user_q <= rsp_user_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.s_req_valid = (state_q == StReq);
    assign bus.s_req_data  = req_data_q;
    assign bus.s_req_addr  = req_addr_q;
    assign bus.s_req_user  = req_user_q;
    assign bus.s_rsp_ready = 1'b1;
    assign bus.m_rsp_valid = (state_q == StRsp) ? (NUM_MASTERS'(1) << grant_q) : '0;
    assign bus.m_rsp_data  = rsp_data_q;
    assign bus.m_rsp_addr  = rsp_addr_q;
    assign bus.m_rsp_user  = rsp_user_q;
    assign bus.m_rsp_err   = rsp_err_q;
    assign stray_cnt       = stray_q;
endmodule

// File: tb/tb_sra_arbiter.sv
// Directed bench for sra_arbiter: round-robin order, timeout, expiry race, stray counting
// and reset abandonment, with every expected value written out by hand.
module tb_sra_arbiter;
    localparam int unsigned NM  = 4;
    localparam int unsigned DWB = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned MU  = 2;
    localparam int unsigned SU  = 2;
    localparam int unsigned TO  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] stray_cnt;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    sra_arbiter_if #(
        .DATA_WIDTH_BYTES(DWB), .ADDR_WIDTH(AW), .M_USER_BITS(MU), .S_USER_BITS(SU),
        .NUM_MASTERS(NM)
    ) bus ();

    sra_arbiter #(
        .DATA_WIDTH_BYTES(DWB), .ADDR_WIDTH(AW), .M_USER_BITS(MU), .S_USER_BITS(SU),
        .NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stray_cnt (stray_cnt)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.m_req_valid = '0;
        bus.m_req_data  = '0;
        bus.m_req_addr  = '0;
        bus.m_req_user  = '0;
        bus.m_rsp_ready = '0;
        bus.s_req_ready = 1'b0;
        bus.s_rsp_valid = 1'b0;
        bus.s_rsp_data  = '0;
        bus.s_rsp_addr  = '0;
        bus.s_rsp_user  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.m_req_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            bus.m_req_addr[i*8 +: 8]   = 8'h40 + 8'(i);
            bus.m_req_user[i*2 +: 2]   = 2'(i);
        end

        // Reset holds ready low even with every master requesting.
        bus.m_req_valid = 4'hF;
        repeat (3) cyc();
        #1;
        check("rst_m_req_ready", 64'(bus.m_req_ready), 64'h0);
        check("rst_s_req_valid", 64'(bus.s_req_valid), 64'h0);
        check("rst_m_rsp_valid", 64'(bus.m_rsp_valid), 64'h0);
        check("rst_m_rsp_err", 64'(bus.m_rsp_err), 64'h0);
        check("rst_s_rsp_ready", 64'(bus.s_rsp_ready), 64'h1);
        check("rst_stray_cnt", 64'(stray_cnt), 64'h0);
        bus.m_req_valid = '0;
        rst = 1'b1;
        cyc();

        // Single transaction from master 1, slave answers after three wait cycles.
        bus.m_req_data[32 +: 32] = 32'hDEAD_BEEF;
        bus.m_req_addr[8 +: 8]   = 8'h10;
        bus.m_req_user[2 +: 2]   = 2'd3;
        bus.m_req_valid          = 4'b0010;
        #1;
        check("t1_grant", 64'(bus.m_req_ready), 64'h2);
        cyc();
        bus.m_req_valid = '0;
        check("t1_ready_in_req", 64'(bus.m_req_ready), 64'h0);
        check("t1_s_req_valid", 64'(bus.s_req_valid), 64'h1);
        check("t1_s_req_data", 64'(bus.s_req_data), 64'hDEAD_BEEF);
        check("t1_s_req_addr", 64'(bus.s_req_addr), 64'h10);
        check("t1_s_req_user", 64'(bus.s_req_user), 64'h3);
        bus.s_req_ready = 1'b1;
        cyc();
        bus.s_req_ready = 1'b0;
        check("t1_wait_s_req_valid", 64'(bus.s_req_valid), 64'h0);
        check("t1_wait_s_rsp_ready", 64'(bus.s_rsp_ready), 64'h1);
        cyc();
        cyc();
        check("t1_wait_no_rsp", 64'(bus.m_rsp_valid), 64'h0);
        bus.s_rsp_valid = 1'b1;
        bus.s_rsp_data  = 32'h1;
        bus.s_rsp_addr  = 8'h10;
        bus.s_rsp_user  = 2'd1;
        cyc();
        bus.s_rsp_valid = 1'b0;
        check("t1_m_rsp_valid", 64'(bus.m_rsp_valid), 64'h2);
        check("t1_m_rsp_data", 64'(bus.m_rsp_data), 64'h1);
        check("t1_m_rsp_addr", 64'(bus.m_rsp_addr), 64'h10);
        check("t1_m_rsp_user", 64'(bus.m_rsp_user), 64'h1);
        check("t1_m_rsp_err", 64'(bus.m_rsp_err), 64'h0);
        bus.m_rsp_ready = 4'b0010;
        cyc();
        bus.m_rsp_ready = '0;
        check("t1_rsp_done", 64'(bus.m_rsp_valid), 64'h0);
        check("t1_stray", 64'(stray_cnt), 64'h0);

        // Reset pulse returns rr_ptr to 0; all masters then win in turn.
        bus.m_req_data[32 +: 32] = 32'hA000_0001;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        bus.m_req_valid = 4'hF;
        bus.m_rsp_ready = 4'hF;
        bus.s_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 64'(bus.m_req_ready), 64'(4'b0001 << (k % 4)));
            cyc();
            check("rr_s_req_data", 64'(bus.s_req_data), 64'(32'hA000_0000 + 32'(k % 4)));
            cyc();
            bus.s_rsp_valid = 1'b1;
            bus.s_rsp_data  = 32'h100 + 32'(k);
            cyc();
            bus.s_rsp_valid = 1'b0;
            check("rr_m_rsp_valid", 64'(bus.m_rsp_valid), 64'(4'b0001 << (k % 4)));
            check("rr_m_rsp_data", 64'(bus.m_rsp_data), 64'(32'h100 + 32'(k)));
            cyc();
        end
        bus.m_req_valid = '0;
        bus.m_rsp_ready = '0;
        bus.s_req_ready = 1'b0;

        // Timeout: rr_ptr is 1, master 2 requests, slave stays silent.
        bus.m_req_addr[16 +: 8] = 8'h22;
        bus.m_req_valid         = 4'b0100;
        #1;
        check("to_grant", 64'(bus.m_req_ready), 64'h4);
        cyc();
        bus.m_req_valid = '0;
        bus.s_req_ready = 1'b1;
        cyc();
        bus.s_req_ready = 1'b0;
        repeat (7) cyc();
        check("to_not_yet", 64'(bus.m_rsp_valid), 64'h0);
        cyc();
        check("to_m_rsp_valid", 64'(bus.m_rsp_valid), 64'h4);
        check("to_m_rsp_err", 64'(bus.m_rsp_err), 64'h1);
        check("to_m_rsp_data", 64'(bus.m_rsp_data), 64'h0);
        check("to_m_rsp_user", 64'(bus.m_rsp_user), 64'h0);
        check("to_m_rsp_addr", 64'(bus.m_rsp_addr), 64'h22);

        // Master 2 stalls; a late slave response is counted as stray and never forwarded.
        bus.m_req_valid = 4'hF;
        bus.s_rsp_valid = 1'b1;
        bus.s_rsp_data  = 32'h55;
        for (int h = 0; h < 5; h++) begin
            cyc();
            bus.s_rsp_valid = 1'b0;
            check("hold_m_rsp_valid", 64'(bus.m_rsp_valid), 64'h4);
            check("hold_m_rsp_data", 64'(bus.m_rsp_data), 64'h0);
            check("hold_no_grant", 64'(bus.m_req_ready), 64'h0);
        end
        check("late_stray", 64'(stray_cnt), 64'h1);
        bus.m_rsp_ready = 4'b0100;
        cyc();
        bus.m_rsp_ready = '0;
        check("after_to_grant", 64'(bus.m_req_ready), 64'h8);

        // Slave response lands in the expiry cycle and wins.
        cyc();
        bus.m_req_valid = '0;
        bus.s_req_ready = 1'b1;
        check("race_s_req_data", 64'(bus.s_req_data), 64'hA000_0003);
        cyc();
        bus.s_req_ready = 1'b0;
        repeat (7) cyc();
        bus.s_rsp_valid = 1'b1;
        bus.s_rsp_data  = 32'hCAFE_0001;
        bus.s_rsp_addr  = 8'h33;
        bus.s_rsp_user  = 2'd2;
        cyc();
        bus.s_rsp_valid = 1'b0;
        check("race_m_rsp_valid", 64'(bus.m_rsp_valid), 64'h8);
        check("race_m_rsp_err", 64'(bus.m_rsp_err), 64'h0);
        check("race_m_rsp_data", 64'(bus.m_rsp_data), 64'hCAFE_0001);
        check("race_m_rsp_addr", 64'(bus.m_rsp_addr), 64'h33);
        check("race_stray", 64'(stray_cnt), 64'h1);
        bus.m_rsp_ready = 4'hF;
        cyc();
        bus.m_rsp_ready = '0;

        // Reset in the middle of WAIT abandons master 2's transaction.
        bus.m_req_valid = 4'b0100;
        cyc();
        bus.m_req_valid = '0;
        bus.s_req_ready = 1'b1;
        cyc();
        bus.s_req_ready = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check("mid_rst_s_req_valid", 64'(bus.s_req_valid), 64'h0);
        check("mid_rst_m_rsp_valid", 64'(bus.m_rsp_valid), 64'h0);
        check("mid_rst_stray", 64'(stray_cnt), 64'h0);
        rst = 1'b1;
        cyc();
        check("post_rst_no_rsp", 64'(bus.m_rsp_valid), 64'h0);
        bus.m_req_valid = 4'b1001;
        #1;
        check("post_rst_grant", 64'(bus.m_req_ready), 64'h1);
        cyc();
        bus.m_req_valid = '0;
        check("post_rst_s_req_valid", 64'(bus.s_req_valid), 64'h1);
        check("post_rst_s_req_addr", 64'(bus.s_req_addr), 64'h40);

        // Stray responses while stuck in REQ saturate the counter.
        bus.s_rsp_valid = 1'b1;
        repeat (260) cyc();
        bus.s_rsp_valid = 1'b0;
        check("stray_saturate", 64'(stray_cnt), 64'hFF);
        check("stray_req_held", 64'(bus.s_req_valid), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
